addr_source_sequencer: RTL and testbench
========================================

Name: addr_source_sequencer

Overview:
- Sequencer sitting directly upstream of the 4:1 address-bus multiplexer.
- Drives the mux select and enable, plus the PC-increment and address-latch strobes, for one operand-addressing sequence per Start request.
- Walks a per-mode step sequence (immediate, zero page, absolute, absolute-indexed, stack), honours memory Ready stalls, and inserts the page-cross fixup cycle.

Parameters:
- None. Mode table and Sel encoding are fixed.

Ports:
- GlobalClock  in  1  single system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only while idle.
- Mode  in  3  addressing mode; latched on Start acceptance.
- Ready  in  1  memory ready. 0 stalls the current step.
- Page_Cross  in  1  index-adder carry; sampled in ABS_IDX step 2 only.
- Busy  out  1  sequence in progress.
- Done  out  1  one-cycle pulse after the last step completes.
- Bad_Mode  out  1  one-cycle pulse coincident with Done for reserved modes.
- Mux_Enable  out  1  to mux Enable.
- Mux_Sel  out  2  to mux Sel: 00=PC, 01=effective address {ADH,ADL}, 10=zero page {00,ADL}, 11=stack {01,SP}.
- PC_Inc  out  1  increment-PC strobe.
- Load_ADL  out  1  capture data bus into ADL.
- Load_ADH  out  1  capture data bus (or carry-corrected ADH) into ADH.
- Step  out  3  current step index, for debug and trace.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Step=0; latched mode=0; all outputs 0. Release takes effect at the next edge.
- Two states: IDLE and RUN. Step counter 0..4. Mode register holds the latched mode.
- IDLE outputs:
  - Busy=0, Mux_Enable=0, Mux_Sel=00, all strobes 0, Step=0.
  - Done/Bad_Mode are 1 only in the first IDLE cycle after a completed sequence.
- Acceptance:
  - Edge with state IDLE and Start=1 -> RUN, Step=0, Mode latched.
  - Latency Start-to-first-step = 1 cycle.
  - Start while RUN is ignored. Mode changes after acceptance are ignored.
- RUN outputs: Busy=1, Mux_Enable=1 (except reserved modes). Sel and strobes decode combinationally from (latched mode, Step). Strobes are ANDed with Ready. Sel and Enable are not gated by Ready.
- Step tables:
  - Mode 0 IMM: s0 Sel=00, PC_Inc. Last step = s0.
  - Mode 1 ZP:
    - s0 Sel=00, PC_Inc, Load_ADL.
    - s1 Sel=10. Last step.
  - Mode 2 ABS:
    - s0 Sel=00, PC_Inc, Load_ADL.
    - s1 Sel=00, PC_Inc, Load_ADH.
    - s2 Sel=01. Last step.
  - Mode 3 ABS_IDX: s0 and s1 as ABS; then:
    - s2 Sel=01. If Page_Cross=1: Load_ADH, advance to s3. Else s2 is the last step.
    - s3 Sel=01. Last step.
  - Mode 4 STACK: s0 Sel=11. Last step.
  - Modes 5-7 (reserved): s0 with Mux_Enable=0, no strobes. Completes with Bad_Mode=1.
- Advancement: each edge in RUN with Ready=1 advances Step or, at the last step, goes to IDLE with Done=1 for one cycle. Ready=0 holds Step and state. Outputs stay stable and strobes stay 0.
- Page_Cross is sampled on the s2 edge with Ready=1 only. It is ignored during stalls and in other modes.
- Back-to-back: Start=1 in the Done cycle is accepted, giving 1 idle cycle between sequences.
- Reset mid-sequence aborts immediately. No Done is generated.
- Total cycles with Ready=1 from Start edge to Done: IMM 2, ZP 3, ABS 4, ABS_IDX 4 without page cross / 5 with page cross, STACK 2, reserved 2.

Test Plan:
- Reset_n=0 while RUN in ABS s1 -> all outputs 0 immediately; after release, Start=0 -> remains IDLE, no Done.
- Start, Mode=2, Ready=1 -> (Sel,PC_Inc,Load_ADL,Load_ADH) = (00,1,1,0), (00,1,0,1), (01,0,0,0); Done=1 on the 4th cycle after the Start edge.
- Mode=3, Page_Cross=1 at s2 -> s2 asserts Load_ADH with Sel=01, s3 Sel=01, Done 5 cycles after Start. Repeat with Page_Cross=0 -> Done after 4 cycles, no Load_ADH at s2.
- Mode=1, Ready=0 for 3 cycles at s0 -> Sel=00 held, PC_Inc=0 and Load_ADL=0 during the stall; Ready=1 -> one PC_Inc+Load_ADL pulse, then s1 Sel=10; Done 6 cycles after Start.
- Mode=4 with Start held high continuously -> sequences repeat every 2 cycles (s0 Sel=11, then Done cycle re-accepts); Start pulsed mid-RUN of Mode=2 -> ignored.
- Mode=6 -> one cycle with Busy=1 and Mux_Enable=0, then Done=1 and Bad_Mode=1 together for one cycle, no strobes at any time.

Source files
------------

// File: rtl/addr_source_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addr_source_sequencer : per-mode operand-addressing sequencer for the 4:1
// address-bus mux (Sel/Enable, PC-increment and ADL/ADH strobes).  Rev 1.0
// ---------------------------------------------------------------------------
module addr_source_sequencer (
  input  logic       GlobalClock,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [2:0] Mode,
  input  logic       Ready,
  input  logic       Page_Cross,
  output logic       Busy,
  output logic       Done,
  output logic       Bad_Mode,
  output logic       Mux_Enable,
  output logic [1:0] Mux_Sel,
  output logic       PC_Inc,
  output logic       Load_ADL,
  output logic       Load_ADH,
  output logic [2:0] Step
);

  localparam logic [2:0] MODE_IMM     = 3'd0;
  localparam logic [2:0] MODE_ZP      = 3'd1;
  localparam logic [2:0] MODE_ABS     = 3'd2;
  localparam logic [2:0] MODE_ABS_IDX = 3'd3;
  localparam logic [2:0] MODE_STACK   = 3'd4;

  localparam logic [1:0] SEL_PC = 2'b00;
  localparam logic [1:0] SEL_EA = 2'b01;
  localparam logic [1:0] SEL_ZP = 2'b10;
  localparam logic [1:0] SEL_SP = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] step;
  logic [2:0] mode_q;
  logic       done_q;
  logic       bad_q;

  logic       reserved;
  logic       last_step;
  logic [1:0] sel;
  logic       inc;
  logic       ladl;
  logic       ladh;
  logic       busy;

  // Step table: Sel and raw strobes from (latched mode, step); Page_Cross only
  // matters in ABS_IDX s2, where it both loads ADH and extends the sequence.
  always_comb begin
    sel       = SEL_PC;
    inc       = 1'b0;
    ladl      = 1'b0;
    ladh      = 1'b0;
    last_step = 1'b1;
    reserved  = (mode_q > MODE_STACK);
    case (mode_q)
      MODE_IMM: inc = 1'b1;
      MODE_ZP: begin
        if (step == 3'd0) begin
          inc       = 1'b1;
          ladl      = 1'b1;
          last_step = 1'b0;
        end else begin
          sel = SEL_ZP;
        end
      end
      MODE_ABS, MODE_ABS_IDX: begin
        case (step)
          3'd0: begin
            inc       = 1'b1;
            ladl      = 1'b1;
            last_step = 1'b0;
          end
          3'd1: begin
            inc       = 1'b1;
            ladh      = 1'b1;
            last_step = 1'b0;
          end
          3'd2: begin
            sel = SEL_EA;
            if (mode_q == MODE_ABS_IDX && Page_Cross) begin
              ladh      = 1'b1;
              last_step = 1'b0;
            end
          end
          default: sel = SEL_EA;
        endcase
      end
      MODE_STACK: sel = SEL_SP;
      default: ;
    endcase
  end

  always_ff @(posedge GlobalClock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      step   <= 3'd0;
      mode_q <= 3'd0;
      done_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      bad_q  <= 1'b0;
      case (state)
        IDLE: begin
          step <= 3'd0;
          if (Start) begin
            state  <= RUN;
            mode_q <= Mode;
          end
        end
        RUN: begin
          if (Ready) begin
            if (last_step) begin
              state  <= IDLE;
              step   <= 3'd0;
              done_q <= 1'b1;
              bad_q  <= reserved;
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == RUN);
  assign Busy       = busy;
  assign Done       = done_q;
  assign Bad_Mode   = bad_q;
  assign Mux_Enable = busy & ~reserved;
  assign Mux_Sel    = busy ? sel : SEL_PC;
  assign PC_Inc     = busy & Ready & inc;
  assign Load_ADL   = busy & Ready & ladl;
  assign Load_ADH   = busy & Ready & ladh;
  assign Step       = step;

endmodule
`default_nettype wire

// File: tb/tb_addr_source_sequencer.sv
`default_nettype none
// Directed bench for addr_source_sequencer; all expectations are hand-computed
// output vectors {Busy,Done,Bad_Mode,Mux_Enable,Mux_Sel,PC_Inc,Load_ADL,Load_ADH,Step}.
module tb_addr_source_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] mode;
  logic       ready;
  logic       pc;
  logic       busy;
  logic       done;
  logic       bad;
  logic       en;
  logic [1:0] sel;
  logic       inc;
  logic       ladl;
  logic       ladh;
  logic [2:0] step;

  int total = 0;
  int bad_cnt = 0;

  addr_source_sequencer dut (
    .GlobalClock(clk),
    .Reset_n    (rst_n),
    .Start      (start),
    .Mode       (mode),
    .Ready      (ready),
    .Page_Cross (pc),
    .Busy       (busy),
    .Done       (done),
    .Bad_Mode   (bad),
    .Mux_Enable (en),
    .Mux_Sel    (sel),
    .PC_Inc     (inc),
    .Load_ADL   (ladl),
    .Load_ADH   (ladh),
    .Step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] v(input logic b, input logic d, input logic bm,
                                    input logic e, input logic [1:0] s, input logic pi,
                                    input logic la, input logic lh, input logic [2:0] st);
    return {b, d, bm, e, s, pi, la, lh, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] expv);
    logic [11:0] obs;
    #1;
    obs = {busy, done, bad, en, sel, inc, ladl, ladh, step};
    total++;
    assert (obs === expv) else begin
      bad_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  localparam logic [11:0] ZERO = 12'b0;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; ready = 1'b1; pc = 1'b0;
    chk("reset_outputs", ZERO);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", ZERO);

    // ABS with a mode change and a Start pulse mid-run, both ignored
    start = 1'b1; mode = 3'd2;
    chk("abs_pre_accept", ZERO);
    tick(); start = 1'b0; mode = 3'd7;
    chk("abs_s0", v(1,0,0,1,2'b00,1,1,0,3'd0));
    tick(); start = 1'b1;
    chk("abs_s1", v(1,0,0,1,2'b00,1,0,1,3'd1));
    tick(); start = 1'b0;
    chk("abs_s2", v(1,0,0,1,2'b01,0,0,0,3'd2));
    tick();
    chk("abs_done", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();
    chk("abs_done_clear", ZERO);

    // ABS_IDX with page cross
    start = 1'b1; mode = 3'd3;
    tick(); start = 1'b0;
    chk("idx_pc_s0", v(1,0,0,1,2'b00,1,1,0,3'd0));
    tick();
    chk("idx_pc_s1", v(1,0,0,1,2'b00,1,0,1,3'd1));
    tick(); pc = 1'b1;
    chk("idx_pc_s2", v(1,0,0,1,2'b01,0,0,1,3'd2));
    tick(); pc = 1'b0;
    chk("idx_pc_s3", v(1,0,0,1,2'b01,0,0,0,3'd3));
    tick();
    chk("idx_pc_done", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();

    // ABS_IDX without page cross
    start = 1'b1; mode = 3'd3;
    tick(); start = 1'b0;
    tick();
    chk("idx_np_s1", v(1,0,0,1,2'b00,1,0,1,3'd1));
    tick();
    chk("idx_np_s2", v(1,0,0,1,2'b01,0,0,0,3'd2));
    tick();
    chk("idx_np_done", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();

    // ZP with a 3-cycle stall at s0
    start = 1'b1; mode = 3'd1;
    tick(); start = 1'b0; ready = 1'b0;
    chk("zp_stall0", v(1,0,0,1,2'b00,0,0,0,3'd0));
    tick();
    chk("zp_stall1", v(1,0,0,1,2'b00,0,0,0,3'd0));
    tick();
    chk("zp_stall2", v(1,0,0,1,2'b00,0,0,0,3'd0));
    tick(); ready = 1'b1;
    chk("zp_s0_go", v(1,0,0,1,2'b00,1,1,0,3'd0));
    tick();
    chk("zp_s1", v(1,0,0,1,2'b10,0,0,0,3'd1));
    tick();
    chk("zp_done", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();

    // IMM
    start = 1'b1; mode = 3'd0;
    tick(); start = 1'b0;
    chk("imm_s0", v(1,0,0,1,2'b00,1,0,0,3'd0));
    tick();
    chk("imm_done", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();

    // STACK with Start held: back-to-back re-acceptance in the Done cycle
    start = 1'b1; mode = 3'd4;
    tick();
    chk("stk_s0_a", v(1,0,0,1,2'b11,0,0,0,3'd0));
    tick();
    chk("stk_done_a", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();
    chk("stk_s0_b", v(1,0,0,1,2'b11,0,0,0,3'd0));
    tick(); start = 1'b0;
    chk("stk_done_b", v(0,1,0,0,2'b00,0,0,0,3'd0));
    tick();
    chk("stk_idle", ZERO);

    // Reserved mode
    start = 1'b1; mode = 3'd6;
    tick(); start = 1'b0;
    chk("rsv_s0", v(1,0,0,0,2'b00,0,0,0,3'd0));
    tick();
    chk("rsv_done", v(0,1,1,0,2'b00,0,0,0,3'd0));
    tick();
    chk("rsv_clear", ZERO);

    // Async reset in ABS s1 aborts without Done
    start = 1'b1; mode = 3'd2;
    tick(); start = 1'b0;
    tick();
    chk("rst_pre_s1", v(1,0,0,1,2'b00,1,0,1,3'd1));
    rst_n = 1'b0;
    chk("rst_async", ZERO);
    tick(); rst_n = 1'b1;
    tick();
    chk("rst_idle_a", ZERO);
    tick();
    chk("rst_idle_b", ZERO);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
